// File: rtl/pll_reset_seq.sv
// PLL lock qualifier and core reset sequencer with phase-aligned 16/4/1 MHz clock enables.
// Optional RUN->lock-loss event counter, built only when RESET_SEQ_LOSS_CNT_EN is defined.
module pll_reset_seq #(
  parameter int LOCK_HOLD  = 1024,
  parameter int RESET_HOLD = 64
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       pll_locked,
  output logic       core_reset,
  output logic       ready,
  output logic       ce_16,
  output logic       ce_4,
  output logic       ce_1,
  output logic [7:0] lock_loss_cnt
);

  typedef enum logic [1:0] {WAIT_LOCK, STABLE, RELEASE, RUN} state_e;

  localparam logic [15:0] LockTerm  = 16'(LOCK_HOLD - 1);
  localparam logic [15:0] ResetTerm = 16'(RESET_HOLD - 1);

  logic        sync1_q, sync2_q, locked_s;
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [5:0]  div_q, div_d;
  logic        active_d;
  logic        core_reset_q, ready_q, ce_16_q, ce_4_q, ce_1_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      sync2_q <= sync1_q;
    end
  end

  assign locked_s = sync2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (locked_s) state_d = STABLE;
      end
      STABLE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == LockTerm) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RELEASE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == ResetTerm) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!locked_s) state_d = WAIT_LOCK;
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
    div_d    = (state_q == RELEASE || state_q == RUN) ? div_q + 6'd1 : '0;
    active_d = (state_d == RELEASE || state_d == RUN);
  end

  // Outputs are registered from next-state values, so each equals a decode of state_q/div_q
  // in the same cycle while being driven straight from flops.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= WAIT_LOCK;
      cnt_q        <= '0;
      div_q        <= '0;
      core_reset_q <= 1'b1;
      ready_q      <= 1'b0;
      ce_16_q      <= 1'b0;
      ce_4_q       <= 1'b0;
      ce_1_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      core_reset_q <= (state_d != RUN);
      ready_q      <= (state_d == RUN);
      ce_16_q      <= active_d && (div_d[1:0] == 2'b11);
      ce_4_q       <= active_d && (div_d[3:0] == 4'hF);
      ce_1_q       <= active_d && (div_d == '1);
    end
  end

  assign core_reset = core_reset_q;
  assign ready      = ready_q;
  assign ce_16      = ce_16_q;
  assign ce_4       = ce_4_q;
  assign ce_1       = ce_1_q;

`ifdef RESET_SEQ_LOSS_CNT_EN
  logic [7:0] loss_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      loss_q <= '0;
    end else if (state_q == RUN && state_d == WAIT_LOCK && loss_q != 8'hFF) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign lock_loss_cnt = loss_q;
`else
  assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Scoreboard bench for pll_reset_seq: a short-hold instance (4/8) and a default-parameter instance.
// Stimulus pushes per-edge expectations derived from the release/loss timing; a monitor pops and compares.
module tb_pll_reset_seq;

`ifdef RESET_SEQ_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  localparam int LH_S = 4;
  localparam int RH_S = 8;
  localparam int LH_D = 1024;
  localparam int RH_D = 64;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic       rst_s, rst_d, lk_s, lk_d;
  logic       cr_s, rd_s, c16_s, c4_s, c1_s;
  logic       cr_d, rd_d, c16_d, c4_d, c1_d;
  logic [7:0] llc_s, llc_d;

  pll_reset_seq #(.LOCK_HOLD(LH_S), .RESET_HOLD(RH_S)) dut_s (
    .clk_sys(clk_sys), .reset(rst_s), .pll_locked(lk_s),
    .core_reset(cr_s), .ready(rd_s), .ce_16(c16_s), .ce_4(c4_s), .ce_1(c1_s),
    .lock_loss_cnt(llc_s)
  );

  pll_reset_seq #(.LOCK_HOLD(LH_D), .RESET_HOLD(RH_D)) dut_d (
    .clk_sys(clk_sys), .reset(rst_d), .pll_locked(lk_d),
    .core_reset(cr_d), .ready(rd_d), .ce_16(c16_d), .ce_4(c4_d), .ce_1(c1_d),
    .lock_loss_cnt(llc_d)
  );

  typedef struct {
    int          inst;
    int          n;
    logic [12:0] exp;
  } chk_t;

  chk_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   n     = 0;

  // Per-instance timeline: edge of the lock rise, edge of the first low sample, loss bookkeeping.
  int lh[2], rh[2], rise[2], fall[2], lcnt[2];
  bit wasrun[2];

  // Expected {core_reset, ready, ce_16, ce_4, ce_1} after edge e, edge 1 = first lock sample.
  function automatic logic [4:0] timeline(input int e, input int h, input int r);
    logic [4:0] v;
    int rs, ru, d;
    rs = 3 + h;
    ru = 3 + h + r;
    v  = 5'b10000;
    if (e >= rs) begin
      d    = (e - rs) % 64;
      v[4] = (e < ru);
      v[3] = (e >= ru);
      v[2] = (d % 4 == 3);
      v[1] = (d % 16 == 15);
      v[0] = (d == 63);
    end
    return v;
  endfunction

  task automatic track(input int i, input logic rst, input logic lk);
    logic [4:0] v;
    if (rst) begin
      rise[i] = -1;
      fall[i] = -1;
      lcnt[i] = 0;
    end else if (lk && (rise[i] < 0 || fall[i] >= 0)) begin
      rise[i] = n;
      fall[i] = -1;
    end else if (!lk && rise[i] >= 0 && fall[i] < 0) begin
      fall[i]   = n;
      wasrun[i] = (n - rise[i] + 2) >= (3 + lh[i] + rh[i]);
    end
    if (!rst && fall[i] >= 0 && n == fall[i] + 2 && wasrun[i] && LOSS_EN && lcnt[i] < 255)
      lcnt[i]++;
    if (rst || rise[i] < 0 || (fall[i] >= 0 && n >= fall[i] + 2)) v = 5'b10000;
    else v = timeline(n - rise[i] + 1, lh[i], rh[i]);
    sb.push_back('{inst: i, n: n, exp: {v, 8'(lcnt[i])}});
  endtask

  task automatic step(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk_sys);
      n++;
      #1;
      track(0, rst_s, lk_s);
      track(1, rst_d, lk_d);
    end
  endtask

  always @(negedge clk_sys) begin
    while (sb.size() > 0) begin
      chk_t        c;
      logic [12:0] act;
      c   = sb.pop_front();
      act = (c.inst == 0) ? {cr_s, rd_s, c16_s, c4_s, c1_s, llc_s}
                          : {cr_d, rd_d, c16_d, c4_d, c1_d, llc_d};
      total++;
      if (act !== c.exp) begin
        bad++;
        $display("FAIL inst%0d_edge%0d {rst,rdy,ce16,ce4,ce1,loss}: got %b want %b",
                 c.inst, c.n, act, c.exp);
      end
    end
  end

  initial begin
    lh     = '{LH_S, LH_D};
    rh     = '{RH_S, RH_D};
    rise   = '{-1, -1};
    fall   = '{-1, -1};
    lcnt   = '{0, 0};
    wasrun = '{1'b0, 1'b0};

    // Reset held with lock already high on the default instance
    rst_s = 1'b1; rst_d = 1'b1; lk_s = 1'b0; lk_d = 1'b1;
    step(10);
    rst_s = 1'b0; rst_d = 1'b0;
    step(5);

    // Full sequence on the short instance, long enough to see several ce_1 periods
    lk_s = 1'b1; step(150);

    // Loss in RUN, then relock
    lk_s = 1'b0; step(3);
    lk_s = 1'b1; step(30);

    // 3-cycle drop in the middle of STABLE restarts the hold count
    lk_s = 1'b0; step(4);
    lk_s = 1'b1; step(3);
    lk_s = 1'b0; step(3);
    lk_s = 1'b1; step(30);

    // Loss coinciding with the RESET_HOLD terminal count
    lk_s = 1'b0; step(4);
    lk_s = 1'b1; step(12);
    lk_s = 1'b0; step(6);
    lk_s = 1'b1; step(30);

    // Repeated RUN -> loss cycles drive the loss counter into saturation
    for (int k = 0; k < 300; k++) begin
      lk_s = 1'b0; step(3);
      lk_s = 1'b1; step(16);
    end
    step(2);

    @(negedge clk_sys);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
